drive_z_corr_accum: RTL

DRIVE_Z_CORR_ACCUM -- requirements
Module: drive_z_corr_accum

---
 rtl/drive_z_corr_accum_pkg.sv | 21 ++
 rtl/drive_z_corr_bank_tbl.sv | 64 ++++++
 rtl/drive_z_corr_accum.sv | 119 +++++++++++
 3 files changed

// File: rtl/drive_z_corr_accum_pkg.sv
// Shared definitions for the drive Z-correction accumulator: bank instruction
// encodings and the width derivations used by the top and the bank tables.
package drive_z_corr_accum_pkg;

  typedef enum logic [1:0] {
    MODE_NOP  = 2'd0,
    MODE_CORR = 2'd1,
    MODE_RZ   = 2'd2,
    MODE_RSVD = 2'd3
  } bank_mode_e;

  function automatic int total_qubit(input int num_bank, input int num_qubit_per_bank);
    return num_bank * num_qubit_per_bank;
  endfunction

  function automatic int data_width(input int z_corr_width, input int num_bank,
                                    input int num_qubit_per_bank);
    return z_corr_width * total_qubit(num_bank, num_qubit_per_bank);
  endfunction

endpackage

// File: rtl/drive_z_corr_bank_tbl.sv
// One bank: host-written correction table, registered row read (S1->S2) and
// the S2 contribution select (table row, replicated RZ immediate, or zero).
module drive_z_corr_bank_tbl
  import drive_z_corr_accum_pkg::*;
#(
  parameter int BANK_IDX                  = 0,
  parameter int NUM_BANK                  = 2,
  parameter int NUM_QUBIT_PER_BANK        = 16,
  parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
  parameter int Z_CORR_WIDTH              = 12,
  localparam int DATA_WIDTH = data_width(Z_CORR_WIDTH, NUM_BANK, NUM_QUBIT_PER_BANK)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 advance,
  input  logic                                 wr_en,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] rd_addr,
  input  logic [1:0]                           rd_mode,
  input  logic [Z_CORR_WIDTH-1:0]              rd_imm,
  output logic [DATA_WIDTH-1:0]                contrib
);

  logic [DATA_WIDTH-1:0]   mem [NUM_QUBIT_PER_BANK];
  logic [DATA_WIDTH-1:0]   row_q;
  logic [1:0]              mode_q;
  logic [Z_CORR_WIDTH-1:0] imm_q;

  // Host writes are independent of the pipeline stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_QUBIT_PER_BANK; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read samples the array before a same-edge write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      mode_q <= '0;
      imm_q  <= '0;
    end else if (advance) begin
      row_q  <= mem[rd_addr];
      mode_q <= rd_mode;
      imm_q  <= rd_imm;
    end
  end

  always_comb begin
    contrib = '0;
    case (bank_mode_e'(mode_q))
      MODE_CORR: contrib = row_q;
      MODE_RZ: begin
        for (int q = 0; q < NUM_QUBIT_PER_BANK; q++)
          contrib[(BANK_IDX*NUM_QUBIT_PER_BANK + q)*Z_CORR_WIDTH +: Z_CORR_WIDTH] = imm_q;
      end
      default: contrib = '0;
    endcase
  end

endmodule

// File: rtl/drive_z_corr_accum.sv
// Drive Z-correction accumulator: per-bank table/immediate lookups summed across
// banks into a per-qubit increment and accumulated modulo 2^Z_CORR_WIDTH.
module drive_z_corr_accum
  import drive_z_corr_accum_pkg::*;
#(
  parameter int NUM_BANK                  = 2,
  parameter int NUM_QUBIT_PER_BANK        = 16,
  parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
  parameter int Z_CORR_WIDTH              = 12,
  localparam int TOTAL_QUBIT = total_qubit(NUM_BANK, NUM_QUBIT_PER_BANK),
  localparam int DATA_WIDTH  = data_width(Z_CORR_WIDTH, NUM_BANK, NUM_QUBIT_PER_BANK)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          tbl_wr_en,
  input  logic [NUM_BANK-1:0]                           tbl_wr_sel,
  input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]          tbl_wr_addr,
  input  logic [DATA_WIDTH-1:0]                         tbl_wr_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_BANK*QUBIT_ADDR_WIDTH_PER_BANK-1:0] qubit_sel,
  input  logic [NUM_BANK*2-1:0]                         bank_mode,
  input  logic [NUM_BANK*Z_CORR_WIDTH-1:0]              phase_imm,
  input  logic                                          acc_clear,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         z_corr_out,
  output logic [DATA_WIDTH-1:0]                         delta_out
);

  localparam int AW = QUBIT_ADDR_WIDTH_PER_BANK;
  localparam int W  = Z_CORR_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid && ready. The
  // whole pipeline moves as one; it advances whenever the output register is
  // empty or being drained, and in_ready is exactly that advance condition.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                 s1_valid, s2_valid, s3_valid;
  logic [NUM_BANK*AW-1:0] s1_sel;
  logic [NUM_BANK*2-1:0]  s1_mode;
  logic [NUM_BANK*W-1:0]  s1_imm;
  logic [DATA_WIDTH-1:0]  contrib [NUM_BANK];
  logic [DATA_WIDTH-1:0]  bank_sum, s3_delta, acc, acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
      s1_mode  <= '0;
      s1_imm   <= '0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s3_delta <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sel   <= qubit_sel;
      s1_mode  <= bank_mode;
      s1_imm   <= phase_imm;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s3_delta <= bank_sum;
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    drive_z_corr_bank_tbl #(
      .BANK_IDX                 (b),
      .NUM_BANK                 (NUM_BANK),
      .NUM_QUBIT_PER_BANK       (NUM_QUBIT_PER_BANK),
      .QUBIT_ADDR_WIDTH_PER_BANK(QUBIT_ADDR_WIDTH_PER_BANK),
      .Z_CORR_WIDTH             (Z_CORR_WIDTH)
    ) u_tbl (
      .clk    (clk),
      .rst    (rst),
      .advance(advance),
      .wr_en  (tbl_wr_en && tbl_wr_sel[b]),
      .wr_addr(tbl_wr_addr),
      .wr_data(tbl_wr_data),
      .rd_addr(s1_sel[b*AW +: AW]),
      .rd_mode(s1_mode[b*2 +: 2]),
      .rd_imm (s1_imm[b*W +: W]),
      .contrib(contrib[b])
    );
  end

  // Per-qubit lanes are W bits wide, so each addition wraps naturally.
  always_comb begin
    bank_sum = '0;
    for (int b = 0; b < NUM_BANK; b++)
      for (int q = 0; q < TOTAL_QUBIT; q++)
        bank_sum[q*W +: W] = bank_sum[q*W +: W] + contrib[b][q*W +: W];
  end

  always_comb begin
    acc_next = acc_clear ? '0 : acc;
    if (s3_valid)
      for (int q = 0; q < TOTAL_QUBIT; q++)
        acc_next[q*W +: W] = acc_next[q*W +: W] + s3_delta[q*W +: W];
  end

  // Clear also waits for advance so a stalled result stays stable on the port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      acc       <= '0;
      delta_out <= '0;
    end else if (advance) begin
      out_valid <= s3_valid;
      acc       <= acc_next;
      if (s3_valid) delta_out <= s3_delta;
    end
  end

  assign z_corr_out = acc;

endmodule
